// File: rtl/m_prog_loader.sv
// Boot-time program loader: packs UART bytes into little-endian words, fills imem,
// then dmem through the cached init port, then releases the core reset.
//
// state  | meaning
// S_IMEM | assembling words and writing them to instruction memory
// S_DMEM | assembling words and handing them to the dmem init port
// S_WAIT | load complete, counting down before releasing the core reset
// S_RUN  | core running; loader idle until the next reset
module m_prog_loader #(
    parameter int IADDR_W     = 9,
    parameter int IMEM_WORDS  = 512,
    parameter int DMEM_WORDS  = 0,
    parameter int TIMEOUT_CYC = 65535,
    parameter int RST_DELAY   = 4
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic [7:0]         w_rx_data,
    input  logic               w_rx_en,
    output logic               o_imem_we,
    output logic [IADDR_W-1:0] o_imem_addr,
    output logic [31:0]        o_imem_data,
    output logic [3:0]         o_dmem_wen,
    output logic [31:0]        o_dmem_addr,
    output logic [31:0]        o_dmem_data,
    input  logic               i_dmem_stall,
    output logic               o_init_done,
    output logic               o_core_rstx,
    output logic [31:0]        o_word_cnt,
    output logic               o_err
);

    typedef enum logic [1:0] {S_IMEM, S_DMEM, S_WAIT, S_RUN} state_t;

    localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] DLY_LOAD  = 32'(RST_DELAY - 1);
    localparam logic [31:0] IMEM_LAST = 32'(IMEM_WORDS - 1);
    localparam logic [31:0] DMEM_LAST = 32'(DMEM_WORDS - 1);

    state_t      state;
    logic [31:0] asm_data;
    logic [1:0]  byte_cnt;
    logic [31:0] to_cnt;
    logic [31:0] dly_cnt;

    logic [31:0] word_new;
    logic        loading;
    logic        word_done;
    logic        dmem_accept;

    assign word_new    = {w_rx_data, asm_data[31:8]};
    assign loading     = (state == S_IMEM) || (state == S_DMEM);
    assign word_done   = loading && w_rx_en && (byte_cnt == 2'd3);
    assign dmem_accept = (state == S_DMEM) && (o_dmem_wen != 4'h0) && !i_dmem_stall;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state       <= S_IMEM;
            asm_data    <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            dly_cnt     <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_dmem_wen  <= 4'h0;
            o_dmem_addr <= '0;
            o_dmem_data <= '0;
            o_init_done <= 1'b0;
            o_core_rstx <= 1'b0;
            o_word_cnt  <= '0;
            o_err       <= 1'b0;
        end else begin
            o_imem_we <= 1'b0;

            // Byte assembly and mid-word timeout (down-counter, reloaded on every byte)
            if (loading) begin
                if (w_rx_en) begin
                    asm_data <= word_new;
                    byte_cnt <= byte_cnt + 2'd1;
                    to_cnt   <= TO_LOAD;
                end else if (byte_cnt != 2'd0) begin
                    if (to_cnt == 32'd0) begin
                        byte_cnt <= 2'd0;
                        to_cnt   <= TO_LOAD;
                    end else begin
                        to_cnt <= to_cnt - 32'd1;
                    end
                end
            end

            case (state)
                S_IMEM: begin
                    if (word_done) begin
                        o_imem_we   <= 1'b1;
                        o_imem_addr <= o_word_cnt[IADDR_W-1:0];
                        o_imem_data <= word_new;
                        if (o_word_cnt == IMEM_LAST) begin
                            o_word_cnt <= '0;
                            if (DMEM_WORDS == 0) begin
                                state       <= S_WAIT;
                                o_init_done <= 1'b1;
                                dly_cnt     <= DLY_LOAD;
                                byte_cnt    <= 2'd0;
                            end else begin
                                state <= S_DMEM;
                            end
                        end else begin
                            o_word_cnt <= o_word_cnt + 32'd1;
                        end
                    end
                end
                S_DMEM: begin
                    // A word finishing while the previous one is still pending is lost
                    if (word_done) begin
                        if (o_dmem_wen != 4'h0) begin
                            o_err <= 1'b1;
                        end else begin
                            o_dmem_wen  <= 4'hf;
                            o_dmem_addr <= o_word_cnt << 2;
                            o_dmem_data <= word_new;
                        end
                    end
                    if (dmem_accept) begin
                        o_dmem_wen <= 4'h0;
                        if (o_word_cnt == DMEM_LAST) begin
                            o_word_cnt  <= '0;
                            state       <= S_WAIT;
                            o_init_done <= 1'b1;
                            dly_cnt     <= DLY_LOAD;
                            byte_cnt    <= 2'd0;
                        end else begin
                            o_word_cnt <= o_word_cnt + 32'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (dly_cnt == 32'd0) begin
                        o_core_rstx <= 1'b1;
                        state       <= S_RUN;
                    end else begin
                        dly_cnt <= dly_cnt - 32'd1;
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state <= S_IMEM;
                end
            endcase
        end
    end

endmodule
